// File: rtl/shared_mem_bank_arbiter_if.sv
// Request/response and bank-side bus for shared_mem_bank_arbiter.
// slave: arbiter side; master: issue logic plus bank array side.
interface shared_mem_bank_arbiter_if #(
  parameter int NUM_LANES  = 4,
  parameter int NUM_BANKS  = 4,
  parameter int BANK_DEPTH = 32,
  parameter int DATA_WIDTH = 16
);
  localparam int BS = $clog2(NUM_BANKS);
  localparam int RW = $clog2(BANK_DEPTH);
  localparam int AW = BS + RW;
  localparam int PW = $clog2(NUM_LANES) + 1;

  logic                            req_valid;
  logic                            req_ready;
  logic                            req_write;
  logic [NUM_LANES-1:0]            req_lane_mask;
  logic [NUM_LANES*AW-1:0]         req_addr;
  logic [NUM_LANES*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_BANKS-1:0]            bank_write_en;
  logic [NUM_BANKS*RW-1:0]         bank_addr;
  logic [NUM_BANKS*DATA_WIDTH-1:0] bank_write_data;
  logic [NUM_BANKS*DATA_WIDTH-1:0] bank_read_data;
  logic                            resp_valid;
  logic [NUM_LANES*DATA_WIDTH-1:0] resp_rdata;
  logic [PW-1:0]                   resp_passes;

  modport slave (
    input  req_valid, req_write, req_lane_mask,
    input  req_addr, req_wdata, bank_read_data,
    output req_ready, bank_write_en, bank_addr,
    output bank_write_data, resp_valid,
    output resp_rdata, resp_passes
  );

  modport master (
    output req_valid, req_write, req_lane_mask,
    output req_addr, req_wdata, bank_read_data,
    input  req_ready, bank_write_en, bank_addr,
    input  bank_write_data, resp_valid,
    input  resp_rdata, resp_passes
  );
endinterface

// File: rtl/shared_mem_bank_arbiter.sv
// Multi-lane shared-memory request arbiter: serializes bank conflicts
// into passes, broadcasts same-address loads, one completion per request.
// Ports: clk, rst_n (async low), bus (slave: req_*, bank_*, resp_*).
module shared_mem_bank_arbiter #(
  parameter int NUM_LANES  = 4,
  parameter int NUM_BANKS  = 4,
  parameter int BANK_DEPTH = 32,
  parameter int DATA_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  shared_mem_bank_arbiter_if.slave   bus
);
  localparam int NL = NUM_LANES;
  localparam int NB = NUM_BANKS;
  localparam int DW = DATA_WIDTH;
  localparam int BS = $clog2(NUM_BANKS);
  localparam int RW = $clog2(BANK_DEPTH);
  localparam int AW = BS + RW;
  localparam int PW = $clog2(NUM_LANES) + 1;
  localparam int LW = (NL > 1) ? $clog2(NL) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

  state_t state_q, state_d;

  logic                   wr_q;
  logic [NL-1:0][AW-1:0]  addr_q;
  logic [NL-1:0][DW-1:0]  wdata_q;
  logic [NL-1:0]          pend_q;
  logic [NL-1:0]          served_q;
  logic [NL-1:0]          served;
  logic [PW-1:0]          pass_q;
  logic [NL-1:0][DW-1:0]  rdata_q;
  logic                   resp_valid_q;
  logic [PW-1:0]          resp_passes_q;

  logic [NL-1:0][BS-1:0]  lbank;
  logic [NL-1:0][RW-1:0]  lrow;
  logic [NB-1:0]          have;
  logic [NB-1:0][LW-1:0]  win_idx;
  logic [NB-1:0][RW-1:0]  win_row;
  logic [NB-1:0][DW-1:0]  win_dat;
  logic [NB-1:0][DW-1:0]  brd;

  assign brd = bus.bank_read_data;

  always_comb begin
    for (int i = 0; i < NL; i++) begin
      lbank[i] = addr_q[i][BS-1:0];
      lrow[i]  = addr_q[i][AW-1:BS];
    end
  end

  // Descending scan: the lowest pending lane is written last and wins.
  always_comb begin
    have    = '0;
    win_idx = '0;
    win_row = '0;
    win_dat = '0;
    served  = '0;
    for (int i = NL - 1; i >= 0; i--) begin
      if (state_q == ISSUE && pend_q[i]) begin
        have[lbank[i]]    = 1'b1;
        win_idx[lbank[i]] = LW'(i);
        win_row[lbank[i]] = lrow[i];
        win_dat[lbank[i]] = wdata_q[i];
      end
    end
    // Loads sharing the winner's row ride along as a broadcast.
    for (int i = 0; i < NL; i++) begin
      if (state_q == ISSUE && pend_q[i]) begin
        served[i] = (win_idx[lbank[i]] == LW'(i)) ||
                    (!wr_q && win_row[lbank[i]] == lrow[i]);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.req_valid) state_d = ISSUE;
      ISSUE:   if ((pend_q & ~served) == '0) state_d = DRAIN;
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready       = (state_q == IDLE);
  assign bus.bank_write_en   = have & {NB{wr_q}};
  assign bus.bank_addr       = win_row;
  assign bus.bank_write_data = wr_q ? win_dat : '0;
  assign bus.resp_valid      = resp_valid_q;
  assign bus.resp_rdata      = rdata_q;
  assign bus.resp_passes     = resp_passes_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      wr_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      pend_q        <= '0;
      served_q      <= '0;
      pass_q        <= '0;
      rdata_q       <= '0;
      resp_valid_q  <= 1'b0;
      resp_passes_q <= '0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= 1'b0;
      served_q     <= served & {NL{~wr_q}};
      // Bank data for last cycle's served loads is valid now.
      for (int i = 0; i < NL; i++) begin
        if (served_q[i]) rdata_q[i] <= brd[lbank[i]];
      end
      unique case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            wr_q    <= bus.req_write;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            pend_q  <= bus.req_lane_mask;
            pass_q  <= '0;
            rdata_q <= '0;
          end
        end
        ISSUE: begin
          pend_q <= pend_q & ~served;
          pass_q <= pass_q + PW'(1);
        end
        DRAIN: begin
          resp_valid_q  <= 1'b1;
          resp_passes_q <= pass_q;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_shared_mem_bank_arbiter.sv
// Bench for shared_mem_bank_arbiter: vector table, hand sequences,
// random requests against a bank-count/memory reference model.
module tb_shared_mem_bank_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mem_clr = 1'b1;

  always #5 clk = ~clk;

  shared_mem_bank_arbiter_if bus ();

  shared_mem_bank_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Bank array: 1-cycle registered read, memory indexed by full address.
  logic [15:0] bmem [128];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int k = 0; k < 128; k++) bmem[k] <= 16'h0;
      bus.bank_read_data <= '0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (bus.bank_write_en[b])
          bmem[{bus.bank_addr[b*5 +: 5], 2'(b)}] <=
            bus.bank_write_data[b*16 +: 16];
        bus.bank_read_data[b*16 +: 16] <=
          bmem[{bus.bank_addr[b*5 +: 5], 2'(b)}];
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: a flat word memory and bank-occupancy counting.
  logic [15:0] ref_mem [128];

  function automatic logic [27:0] pa(input int a0, input int a1,
                                     input int a2, input int a3);
    return {7'(a3), 7'(a2), 7'(a1), 7'(a0)};
  endfunction

  function automatic logic [63:0] pd(input int d0, input int d1,
                                     input int d2, input int d3);
    return {16'(d3), 16'(d2), 16'(d1), 16'(d0)};
  endfunction

  // Loads: a bank needs one pass per distinct row it sees.
  // Stores: a bank needs one pass per lane it sees.
  function automatic int model_passes(input logic w, input logic [3:0] m,
                                      input logic [27:0] a);
    int p;
    p = 1;
    for (int b = 0; b < 4; b++) begin
      logic [31:0] seen;
      int cnt;
      seen = '0;
      cnt = 0;
      for (int i = 0; i < 4; i++) begin
        logic [6:0] ad;
        ad = a[i*7 +: 7];
        if (m[i] && int'(ad[1:0]) == b) begin
          if (w) cnt++;
          else if (!seen[ad[6:2]]) begin
            seen[ad[6:2]] = 1'b1;
            cnt++;
          end
        end
      end
      if (cnt > p) p = cnt;
    end
    return p;
  endfunction

  function automatic logic [63:0] model_read(input logic w,
                                             input logic [3:0] m,
                                             input logic [27:0] a);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 4; i++)
      if (!w && m[i]) r[i*16 +: 16] = ref_mem[a[i*7 +: 7]];
    return r;
  endfunction

  task automatic model_apply(input logic w, input logic [3:0] m,
                             input logic [27:0] a, input logic [63:0] d);
    if (w)
      for (int i = 0; i < 4; i++)
        if (m[i]) ref_mem[a[i*7 +: 7]] = d[i*16 +: 16];
  endtask

  logic [3:0]  log_en   [16];
  logic [19:0] log_addr [16];
  int          log_n;
  int          strobes;

  task automatic run_req(input logic w, input logic [3:0] m,
                         input logic [27:0] a, input logic [63:0] d,
                         output int lat, output logic [2:0] np,
                         output logic [63:0] rd, output logic rdy);
    @(negedge clk);
    bus.req_valid     = 1'b1;
    bus.req_write     = w;
    bus.req_lane_mask = m;
    bus.req_addr      = a;
    bus.req_wdata     = d;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    lat = 0;
    log_n = 0;
    strobes = 0;
    while (lat < 12) begin
      @(negedge clk);
      log_en[log_n]   = bus.bank_write_en;
      log_addr[log_n] = bus.bank_addr;
      log_n++;
      strobes += $countones(bus.bank_write_en);
      @(posedge clk);
      #1;
      lat++;
      if (bus.resp_valid) break;
    end
    if (!bus.resp_valid) lat = 99;
    np  = bus.resp_passes;
    rd  = bus.resp_rdata;
    rdy = bus.req_ready;
  endtask

  task automatic run_model(input string nm, input logic w,
                           input logic [3:0] m, input logic [27:0] a,
                           input logic [63:0] d);
    int lat;
    int p;
    logic [2:0] np;
    logic [63:0] rd;
    logic rdy;
    logic [63:0] er;
    p  = model_passes(w, m, a);
    er = model_read(w, m, a);
    run_req(w, m, a, d, lat, np, rd, rdy);
    check({nm, " passes"}, 64'(np), 64'(p));
    check({nm, " latency"}, 64'(lat), 64'(p + 1));
    check({nm, " rdata"}, rd, er);
    check({nm, " strobes"}, 64'(strobes),
          64'(w ? $countones(m) : 0));
    check({nm, " ready"}, 64'(rdy), 64'(1));
    model_apply(w, m, a, d);
  endtask

  typedef struct {
    logic        w;
    logic [3:0]  m;
    logic [27:0] a;
    logic [63:0] d;
    int          passes;
    logic [63:0] rdata;
    int          strobes;
  } vec_t;

  vec_t vt [12];

  initial begin
    int lat;
    logic [2:0] np;
    logic [63:0] rd;
    logic rdy;
    logic [27:0] ra;
    logic [3:0] rm;
    int bad;

    bus.req_valid      = 1'b0;
    bus.req_write      = 1'b0;
    bus.req_lane_mask  = '0;
    bus.req_addr       = '0;
    bus.req_wdata      = '0;
    for (int k = 0; k < 128; k++) ref_mem[k] = 16'h0;

    vt[0]  = '{1'b1, 4'hF, pa(0, 1, 2, 3),
               pd('h1111, 'h2222, 'h3333, 'h4444), 1, 64'h0, 4};
    vt[1]  = '{1'b0, 4'hF, pa(0, 1, 2, 3), 64'h0, 1,
               pd('h1111, 'h2222, 'h3333, 'h4444), 0};
    vt[2]  = '{1'b1, 4'hF, pa(0, 4, 8, 12),
               pd('h0A00, 'h0A01, 'h0A02, 'h0A03), 4, 64'h0, 4};
    vt[3]  = '{1'b0, 4'hF, pa(0, 4, 8, 12), 64'h0, 4,
               pd('h0A00, 'h0A01, 'h0A02, 'h0A03), 0};
    vt[4]  = '{1'b1, 4'h3, pa(5, 7, 0, 0),
               pd('h5555, 'h7777, 'h9999, 'h9999), 1, 64'h0, 2};
    vt[5]  = '{1'b0, 4'hF, pa(5, 5, 5, 5), 64'h0, 1,
               pd('h5555, 'h5555, 'h5555, 'h5555), 0};
    vt[6]  = '{1'b1, 4'hF, pa(6, 6, 6, 6),
               pd('h000A, 'h000B, 'h000C, 'h000D), 4, 64'h0, 4};
    vt[7]  = '{1'b0, 4'hF, pa(6, 6, 6, 6), 64'h0, 1,
               pd('h000D, 'h000D, 'h000D, 'h000D), 0};
    vt[8]  = '{1'b0, 4'h5, pa(2, 1, 7, 3), 64'h0, 1,
               pd('h3333, 0, 'h7777, 0), 0};
    vt[9]  = '{1'b0, 4'h0, pa(0, 1, 2, 3), 64'h0, 1, 64'h0, 0};
    vt[10] = '{1'b1, 4'h0, pa(0, 1, 2, 3),
               pd('hFFFF, 'hFFFF, 'hFFFF, 'hFFFF), 1, 64'h0, 0};
    vt[11] = '{1'b0, 4'hF, pa(0, 1, 2, 3), 64'h0, 1,
               pd('h0A00, 'h2222, 'h3333, 'h4444), 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    mem_clr = 1'b0;
    rst_n   = 1'b1;
    #1;
    check("reset ready", 64'(bus.req_ready), 64'(1));
    check("reset resp_valid", 64'(bus.resp_valid), 64'(0));
    check("reset passes", 64'(bus.resp_passes), 64'(0));
    check("reset rdata", bus.resp_rdata, 64'h0);
    check("reset write_en", 64'(bus.bank_write_en), 64'(0));

    for (int k = 0; k < 12; k++) begin
      run_req(vt[k].w, vt[k].m, vt[k].a, vt[k].d, lat, np, rd, rdy);
      check($sformatf("vec%0d passes", k), 64'(np), 64'(vt[k].passes));
      check($sformatf("vec%0d latency", k), 64'(lat),
            64'(vt[k].passes + 1));
      check($sformatf("vec%0d rdata", k), rd, vt[k].rdata);
      check($sformatf("vec%0d strobes", k), 64'(strobes),
            64'(vt[k].strobes));
      model_apply(vt[k].w, vt[k].m, vt[k].a, vt[k].d);
    end

    // Conflict-free store: all four strobes in the single pass, row 0.
    run_req(1'b1, 4'hF, pa(0, 1, 2, 3),
            pd('h1111, 'h2222, 'h3333, 'h4444), lat, np, rd, rdy);
    check("cf store en", 64'(log_en[0]), 64'(4'hF));
    check("cf store rows", 64'(log_addr[0]), 64'(0));
    check("cf store latency", 64'(lat), 64'(2));
    model_apply(1'b1, 4'hF, pa(0, 1, 2, 3),
                pd('h1111, 'h2222, 'h3333, 'h4444));

    // 4-way conflict load: bank 0 walks rows 0..3 on consecutive cycles.
    run_req(1'b0, 4'hF, pa(0, 4, 8, 12), 64'h0, lat, np, rd, rdy);
    for (int k = 0; k < 4; k++)
      check($sformatf("conflict row%0d", k),
            64'(log_addr[k][4:0]), 64'(k));
    check("conflict latency", 64'(lat), 64'(5));
    check("conflict rdata", rd,
          pd('h1111, 'h0A01, 'h0A02, 'h0A03));

    for (int n = 0; n < 80; n++) begin
      ra = '0;
      for (int i = 0; i < 4; i++)
        ra[i*7 +: 7] = (n % 3 == 0) ? 7'($urandom_range(0, 127))
                                    : 7'($urandom_range(0, 15));
      rm = 4'($urandom);
      run_model($sformatf("rnd%0d", n), 1'($urandom), rm, ra,
                {$urandom, $urandom});
    end

    // Reset during pass 2 of a 4-way conflict store.
    @(negedge clk);
    bus.req_valid     = 1'b1;
    bus.req_write     = 1'b1;
    bus.req_lane_mask = 4'hF;
    bus.req_addr      = pa(0, 4, 8, 12);
    bus.req_wdata     = pd('h00B0, 'h00B1, 'h00B2, 'h00B3);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("rst pass1 en", 64'(bus.bank_write_en), 64'(1));
    @(posedge clk);
    #2;
    check("rst pass2 en", 64'(bus.bank_write_en), 64'(1));
    rst_n = 1'b0;
    #1;
    check("rst strobes drop", 64'(bus.bank_write_en), 64'(0));
    check("rst resp_valid", 64'(bus.resp_valid), 64'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst ready", 64'(bus.req_ready), 64'(1));
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.resp_valid || bus.bank_write_en != 0) bad++;
    end
    check("rst quiet", 64'(bad), 64'(0));
    ref_mem[0] = 16'h00B0;
    run_model("after rst", 1'b0, 4'hF, pa(0, 4, 8, 12), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/shared_mem_bank_arbiter.md
# shared_mem_bank_arbiter

Sits between a warp's load/store issue and NUM_BANKS Shared_Memory_Subunit banks. Each bank has one read/write port and a 1-cycle registered read. The block accepts one multi-lane shared-memory request and detects bank conflicts between lanes. It serializes conflicting lanes into multiple bank passes, merges same-address reads into one broadcast access, and returns one completion carrying all lanes' read data.

## Interface
- NUM_LANES, 4, lanes per request
- NUM_BANKS, 4, bank count (power of two); BANK_SEL = log2(NUM_BANKS)
- BANK_DEPTH, 32, words per bank; ROW_WIDTH = log2(BANK_DEPTH)
- DATA_WIDTH, 16, word width; ADDRESS_WIDTH = BANK_SEL + ROW_WIDTH (7 by default)

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE
- req_write  in  1  1 = store, 0 = load
- req_lane_mask  in  NUM_LANES  active lanes
- req_addr  in  NUM_LANES*ADDRESS_WIDTH  lane i address at [i*ADDRESS_WIDTH +: ADDRESS_WIDTH]
- req_wdata  in  NUM_LANES*DATA_WIDTH  lane i store data
- bank_write_en  out  NUM_BANKS  per-bank write strobe
- bank_addr  out  NUM_BANKS*ROW_WIDTH  per-bank row
- bank_write_data  out  NUM_BANKS*DATA_WIDTH  per-bank store data
- bank_read_data  in  NUM_BANKS*DATA_WIDTH  bank outputs, valid the cycle after the address is presented
- resp_valid  out  1  one-cycle completion pulse, no backpressure
- resp_rdata  out  NUM_LANES*DATA_WIDTH  per-lane load data
- resp_passes  out  log2(NUM_LANES)+1  bank passes used by the completed request

## Operation
- Address split: bank = addr[BANK_SEL-1:0]; row = addr[ADDRESS_WIDTH-1:BANK_SEL].
- FSM has three states: IDLE, ISSUE, DRAIN.
  - IDLE → ISSUE on req_valid && req_ready. This latches write, mask, addresses and data; pending = lane_mask; pass count = 0; captured read data cleared.
  - ISSUE: one pass per cycle. For each bank, the winner is the lowest-index pending lane mapping to that bank.
    - Load: every pending lane with the same bank and row as the winner is served in the same pass (broadcast).
    - Store: only the winner is served. Same-address stores therefore retire in ascending lane order, and the highest-index lane's data persists.
    - Served lanes are cleared from pending; pass count increments. ISSUE → DRAIN when pending becomes 0.
  - DRAIN: capture the final pass's read data, pulse resp_valid, load resp_passes, → IDLE.
- Bank outputs are combinational from ISSUE state and pending/latched request.
  - bank_write_en[b] = 1 only in ISSUE, on a store, with a winner for b.
  - bank_addr for a bank with no winner is 0.
- For loads, each lane served in a pass captures bank_read_data[its bank] on the following edge, into a per-lane register.
- resp_rdata lanes are 0 for unmasked lanes and for stores.
- Zero lane mask is accepted: one ISSUE cycle with no strobes, resp_passes = 1.
- No request may be accepted outside IDLE; req_valid held while not ready is ignored.

## Timing
- Reset (async, any state): state IDLE, pending 0, resp_valid 0, resp_rdata 0, resp_passes 0, bank_write_en 0. An in-flight request is dropped, with no further bank writes and no response.
- req_ready = (state == IDLE). It is 1 in the cycle resp_valid is high, so back-to-back requests are allowed.
- With P passes, accept at edge E0; passes at E1..EP; resp_valid high the cycle after edge E(P+1). Latency is P+1 cycles (conflict-free = 2).
- P ranges 1..NUM_LANES; the worst case is all lanes hitting one bank with distinct rows (or same-address stores).
- A store retired in pass k is visible to a request accepted at or after the completion edge.

## Test plan
- Conflict-free store: lanes 0-3 to addr 0,1,2,3, data 0x1111/0x2222/0x3333/0x4444.
  - Required: all 4 bank_write_en high in one cycle, row 0; resp_passes = 1; latency 2.
  - A subsequent load of the same addresses returns that data.
- 4-way conflict load: addr 0,4,8,12 (all bank 0, rows 0-3) → bank 0 rows 0,1,2,3 in consecutive cycles; resp_passes = 4; resp_valid 5 cycles after accept; each lane gets its own row's data.
- Broadcast load: all lanes addr 5 → single pass on bank 1 row 1; resp_passes = 1; all 4 lanes return the same word.
- Same-address store: all lanes addr 6, data 0xA,0xB,0xC,0xD → 4 passes in lane order; a later load of addr 6 returns 0xD.
- Mask 0b0101, load addr 2 and 7 → resp_passes = 1; lanes 1 and 3 return 0; mask 0 → resp_passes = 1, latency 2, no strobes.
- rst_n asserted during pass 2 of the 4-way conflict store → strobes drop immediately, no resp_valid, req_ready = 1 after reset release; banks hold only the pass-1 write.
